// File: rtl/humandet_sched.sv
// ============================================================================
// Module   : humandet_sched
// Purpose  : Frame scheduler for the human-detection engine and post stage,
//            with per-frame hit decision and on/off hysteresis. The optional
//            RUN watchdog is enabled by HUMANDET_SCHED_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module humandet_sched #(
    parameter int unsigned       ON_CNT      = 2,
    parameter int unsigned       OFF_CNT     = 3,
    parameter int unsigned       TO_W        = 20,
    parameter logic [TO_W-1:0]   TIMEOUT_CYC = 20'd1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_frame_vld,
    input  logic [3:0]  i_skip,
    input  logic [15:0] i_thresh,
    input  logic [8:0]  i_min_cnt,
    output logic        o_init,
    input  logic        i_comp_done,
    input  logic [15:0] i_max_val,
    input  logic [8:0]  i_cnt_val,
    output logic        o_busy,
    output logic        o_result_vld,
    output logic        o_hit,
    output logic        o_det,
    output logic [15:0] o_max_val,
    output logic [8:0]  o_cnt_val,
    output logic [7:0]  o_drop_cnt,
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2,
        S_EVAL = 2'd3
    } state_t;

    localparam logic [3:0] c_on_cnt  = 4'(ON_CNT);
    localparam logic [3:0] c_off_cnt = 4'(OFF_CNT);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_skip;
    logic [15:0]   r_thresh;
    logic [8:0]    r_min_cnt;
    logic          r_first;
    logic [3:0]    r_hit_strk;
    logic [3:0]    r_miss_strk;
    logic          r_hit;
    logic          r_det;
    logic [15:0]   r_max_val;
    logic [8:0]    r_cnt_val;
    logic [7:0]    r_drop_cnt;

    logic          w_done;
    logic          w_wdog_hit;
    logic          w_to_eval;
    logic          w_hit;
    logic [3:0]    w_hit_strk_inc;
    logic [3:0]    w_miss_strk_inc;

    // Done is ignored on the first RUN cycle: the sticky flag may still be
    // left over from the previous frame until o_init clears it.
    assign w_done = (r_state == S_RUN) && !r_first && i_comp_done;

`ifdef HUMANDET_SCHED_TIMEOUT_EN
    localparam logic [TO_W-1:0] c_to_last = TIMEOUT_CYC - TO_W'(1);

    logic [TO_W-1:0] r_wdog;
    logic            r_to_eval;
    logic            r_timeout;

    assign w_wdog_hit = (r_wdog >= c_to_last);
    assign w_to_eval  = r_to_eval;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog    <= '0;
            r_to_eval <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == S_INIT) begin
                r_wdog <= '0;
            end else if (r_state == S_RUN) begin
                if (r_wdog != {TO_W{1'b1}}) begin
                    r_wdog <= r_wdog + TO_W'(1);
                end
                r_to_eval <= !w_done && w_wdog_hit;
                if (!w_done && w_wdog_hit) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^TIMEOUT_CYC;
    assign w_wdog_hit   = 1'b0;
    assign w_to_eval    = 1'b0;
    assign o_timeout    = 1'b0;
`endif

    assign w_hit = !w_to_eval
                && ($signed(i_max_val) >= $signed(r_thresh))
                && (i_cnt_val >= r_min_cnt);

    assign w_hit_strk_inc  = (r_hit_strk  == 4'hf) ? 4'hf : r_hit_strk  + 4'd1;
    assign w_miss_strk_inc = (r_miss_strk == 4'hf) ? 4'hf : r_miss_strk + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_frame_vld && (r_skip == 4'd0)) w_state_nxt = S_INIT;
            S_INIT: w_state_nxt = S_RUN;
            S_RUN:  if (w_done || w_wdog_hit) w_state_nxt = S_EVAL;
            S_EVAL: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_skip      <= 4'd0;
            r_thresh    <= 16'd0;
            r_min_cnt   <= 9'd0;
            r_first     <= 1'b0;
            r_hit_strk  <= 4'd0;
            r_miss_strk <= 4'd0;
            r_hit       <= 1'b0;
            r_det       <= 1'b0;
            r_max_val   <= 16'd0;
            r_cnt_val   <= 9'd0;
            r_drop_cnt  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state != S_IDLE) && i_frame_vld && (r_drop_cnt != 8'hff)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_frame_vld) begin
                        if (r_skip == 4'd0) begin
                            r_skip    <= i_skip;
                            r_thresh  <= i_thresh;
                            r_min_cnt <= i_min_cnt;
                        end else begin
                            r_skip <= r_skip - 4'd1;
                        end
                    end
                end
                S_INIT: r_first <= 1'b1;
                S_RUN:  r_first <= 1'b0;
                S_EVAL: begin
                    r_hit <= w_hit;
                    if (!w_to_eval) begin
                        r_max_val <= i_max_val;
                        r_cnt_val <= i_cnt_val;
                    end
                    if (w_hit) begin
                        r_miss_strk <= 4'd0;
                        r_hit_strk  <= w_hit_strk_inc;
                        if (w_hit_strk_inc >= c_on_cnt) r_det <= 1'b1;
                    end else begin
                        r_hit_strk  <= 4'd0;
                        r_miss_strk <= w_miss_strk_inc;
                        if (w_miss_strk_inc >= c_off_cnt) r_det <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // o_hit shows the fresh decision during the result strobe, then holds it.
    assign o_init       = (r_state == S_INIT);
    assign o_busy       = (r_state != S_IDLE);
    assign o_result_vld = (r_state == S_EVAL);
    assign o_hit        = (r_state == S_EVAL) ? w_hit : r_hit;
    assign o_det        = r_det;
    assign o_max_val    = r_max_val;
    assign o_cnt_val    = r_cnt_val;
    assign o_drop_cnt   = r_drop_cnt;

endmodule

`default_nettype wire
